mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV and DIVU.
//  Sits directly downstream of the register file: rs_data and rt_data come from read_data1 and read_data2.
//  Produces HI/LO for MFHI/MFLO and for the write-back mux. busy is the stall source for the hazard unit.
//  Also handles MTHI/MTLO direct writes.
// PARAMETERS
//  WIDTH   32  operand width. HI and LO are each WIDTH bits.
//  CNT_W   6   iteration counter width. Must satisfy 2**CNT_W > WIDTH.
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      begin operation; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (signed forms are two's complement)
//  rs_data  in   WIDTH  multiplicand / dividend
//  rt_data  in   WIDTH  multiplier / divisor
//  hi_we    in   1      MTHI: hi <= wr_data (IDLE only)
//  lo_we    in   1      MTLO: lo <= wr_data (IDLE only)
//  wr_data  in   WIDTH  MTHI/MTLO data
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse; hi/lo just updated
//  hi       out  WIDTH  product[63:32] or remainder
//  lo       out  WIDTH  product[31:0] or quotient
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; all internal accumulators cleared. Takes effect immediately, including mid-operation, and aborts that operation.
//  FSM states: IDLE -> MUL | DIV -> FIX -> IDLE.
//  - IDLE: on start, capture operands. Signed ops capture magnitudes plus result signs. busy=1 from the next cycle.
//  - MUL: one shift-add step per cycle over WIDTH steps on an internal 2*WIDTH accumulator.
//  - DIV: one restoring shift-subtract step per cycle over WIDTH steps.
//  - FIX: apply sign correction and write hi/lo. Pulse done=1 for the following cycle; busy=0 in that same cycle.
//  Latency: start sampled at edge 0; edges 1..32 iterate; hi/lo written and done asserted at edge 33. A new start is accepted at edge 34 or later.
//  hi/lo keep their previous values until the FIX edge; intermediate values are never visible.
//  Signs:
//  - Product is negated when the operand signs differ.
//  - Quotient is negated when the signs differ; remainder takes the dividend's sign.
//  Divide by zero: no sign fix. lo=32'hFFFFFFFF, hi=rs_data (raw). Timing is unchanged.
//  DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0 (natural 32-bit wrap). No trap.
//  Boundary and collision cases:
//  - start while busy: ignored. Operands are not re-captured.
//  - hi_we/lo_we while busy: ignored (dropped).
//  - start together with hi_we/lo_we in IDLE: start wins; the write is dropped.
//  - hi_we and lo_we together: both registers written with wr_data.
//  - done cycle: the FSM is in IDLE, so start and MT writes are accepted in that cycle.
//  - op changing after capture: no effect on the running operation.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined:
//  - MUL exits to FIX at any edge where the remaining unshifted multiplier magnitude is 0.
//  - Latency = msb_index(|rt|)+3 edges, for example 2 for rt=0 and 3 for rt=1.
//  - DIV timing is unchanged.
//  MDU_EARLY_OUT_EN undefined: multiply always takes 33 edges. Results are identical either way.
// TESTING
//  1. Reset: rst_n=0 mid-MUL -> busy=0, done=0, hi=0, lo=0 with no clock edge; then a new MULTU runs normally.
//  2. MULTU: rs=32'hFFFFFFFF, rt=32'h00000002 -> done at edge 33, hi=32'h00000001, lo=32'hFFFFFFFE; busy high for edges 1..33.
//  3. MULT: rs=-7 (32'hFFFFFFF9), rt=3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
//  4. DIV: rs=-7, rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU: rs=7, rt=0 -> lo=32'hFFFFFFFF, hi=7.
//  5. Collisions: hi_we=1, wr_data=32'h1234 in IDLE -> hi=32'h1234. Same write while busy -> hi unchanged.
//     start at edge 5 of a running op -> ignored; result still at edge 33.
//  6. MDU_EARLY_OUT_EN: MULTU with rt=0 -> done at edge 2, hi=lo=0. With rt=1 -> done at edge 3, lo=rs.
//     Without the macro, both cases -> done at edge 33.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional: define MDU_EARLY_OUT_EN to end a multiply once the multiplier is exhausted.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  localparam int W2 = 2 * WIDTH;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [W2-1:0]    r_acc;
  logic [W2-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mpl;
  logic [WIDTH-1:0] r_rs_raw;
  logic             r_is_div;
  logic             r_dz;
  logic             r_negq;
  logic             r_negr;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_signed;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic             w_last;
  logic [WIDTH:0]   w_top;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [W2-1:0]    w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_signed = ~op[0];
  assign w_rs_neg = w_signed & rs_data[WIDTH-1];
  assign w_rt_neg = w_signed & rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Shifted partial remainder needs one extra bit before the trial subtract.
  assign w_top  = r_acc[W2-1:WIDTH-1];
  assign w_diff = w_top - {1'b0, r_mcand[WIDTH-1:0]};
  assign w_ge   = ~w_diff[WIDTH];

  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_quo  = r_negq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_negr ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mpl    <= '0;
      r_rs_raw <= '0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_rs_raw <= rs_data;
            r_is_div <= op[1];
            r_dz     <= op[1] & (rt_data == '0);
            r_negq   <= w_rs_neg ^ w_rt_neg;
            r_negr   <= w_rs_neg;
            r_mpl    <= w_rt_mag;
            if (op[1]) begin
              r_acc   <= {{WIDTH{1'b0}}, w_rs_mag};
              r_mcand <= {{WIDTH{1'b0}}, w_rt_mag};
              r_state <= S_DIV;
            end else begin
              r_acc   <= '0;
              r_mcand <= {{WIDTH{1'b0}}, w_rs_mag};
              r_state <= S_MUL;
            end
          end else begin
            if (hi_we) r_hi <= wr_data;
            if (lo_we) r_lo <= wr_data;
          end
        end
        S_MUL: begin
`ifdef MDU_EARLY_OUT_EN
          if (r_mpl == '0) begin
            r_state <= S_FIX;
          end else begin
            if (r_mpl[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_mpl   <= r_mpl >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
`else
          if (r_mpl[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mpl   <= r_mpl >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_FIX;
`endif
        end
        S_DIV: begin
          r_acc <= {w_ge ? w_diff[WIDTH-1:0] : w_top[WIDTH-1:0],
                    r_acc[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod[W2-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_dz) begin
            r_hi <= r_rs_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic model.
// Latency expectations follow MDU_EARLY_OUT_EN when it is defined.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
    int lat;
    logic [31:0] m;
    lat = 33;
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) begin
      m = (!o[0] && b[31]) ? -b : b;
      lat = 2;
      for (int i = 0; i < 32; i++) if (m[i]) lat = i + 3;
    end
`endif
    return lat;
  endfunction

  // poke: start + MT write mid-op; mtw: MT write alongside start; tail: check done drops
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input bit mtw, input bit tail);
    logic [31:0] eh, el;
    int lat, n;
    bit stable, busyok;
    model(o, a, b, eh, el);
    lat = exp_lat(o, b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (mtw) begin
      hi_we = 1'b1; lo_we = 1'b1; wr_data = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    n = 0; stable = 1; busyok = busy;
    while (!done && n < 40) begin
      if (poke && n == 4 && lat > 6) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wr_data = $urandom;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (!done) begin
        if (!busy) busyok = 0;
        if (hi !== m_hi || lo !== m_lo) stable = 0;
      end
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    chk({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, ".busy_run"}, {31'd0, busyok}, 32'd1);
    chk({tag, ".stable"}, {31'd0, stable}, 32'd1);
    m_hi = eh;
    m_lo = el;
    if (tail) begin
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic mt(input string tag, input bit hw, input bit lw,
                    input logic [31:0] d);
    @(negedge clk);
    hi_we = hw; lo_we = lw; wr_data = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    chk({tag, ".hi"}, hi, m_hi);
    chk({tag, ".lo"}, lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'h2, 0, 0, 1);
    run_op("mult", 2'd0, 32'hFFFF_FFF9, 32'd3, 0, 0, 1);
    run_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, 1);
    run_op("divu0", 2'd3, 32'd7, 32'd0, 0, 0, 1);
    run_op("div0s", 2'd2, 32'hFFFF_FFF9, 32'd0, 0, 0, 1);
    run_op("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1);
    run_op("mul_rt0", 2'd1, 32'hDEAD_BEEF, 32'd0, 0, 0, 1);
    run_op("mul_rt1", 2'd1, 32'hDEAD_BEEF, 32'd1, 0, 0, 1);

    mt("mthi", 1, 0, 32'h1234);
    mt("mtlo", 0, 1, 32'h5678);
    mt("mtboth", 1, 1, 32'hCAFE_F00D);
    run_op("poke", 2'd3, 32'd1000, 32'd7, 1, 0, 1);
    run_op("st_mt", 2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1, 1);
    run_op("b2b_a", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    run_op("b2b_b", 2'd2, 32'h8000_0000, 32'd3, 0, 0, 1);

    for (int i = 0; i < 24; i++)
      run_op($sformatf("rnd%0d", i), 2'($urandom), pick(), pick(),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1);

    // asynchronous reset in the middle of a multiply
    mt("pre_rst", 1, 1, 32'hA5A5_A5A5);
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs_data = 32'd99; rt_data = 32'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.busy", {31'd0, busy}, 32'd0);
    chk("mrst.done", {31'd0, done}, 32'd0);
    chk("mrst.hi", hi, 32'd0);
    chk("mrst.lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
